// File: rtl/fifo_pkg.sv
// fifo_pkg: shared async-FIFO constants and Gray/binary pointer helpers
package fifo_pkg;
  localparam int FIFO_ADDR_W = 7;
  localparam int DEPTH = 2**FIFO_ADDR_W;
  localparam int PTR_W = FIFO_ADDR_W + 1;
  function automatic logic [12:0] bin2gray(input logic [12:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [12:0] gray2bin(input logic [12:0] g);
    logic [12:0] b;
    for (int i = 0; i < 13; i++) b[i] = ^(g >> i);
    return b;
  endfunction
endpackage

// File: rtl/gray2bin.sv
// gray2bin: combinational XOR-prefix Gray-to-binary converter
module gray2bin #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_gray,
  output logic [W-1:0] o_bin
);
  always_comb begin
    o_bin = '0;
    for (int i = 0; i < W; i++) o_bin[i] = ^(i_gray >> i);
  end
endmodule

// File: rtl/wrt_ptr_ctrl.sv
// wrt_ptr_ctrl: write-domain pointer, address and full/level/overflow status for the async FIFO
module wrt_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_W    = 7,
  parameter int AF_THRESH = 2**ADDR_W - 4
) (
  input  logic              wrt_clk,
  input  logic              wrt_rst_n,
  input  logic              wrt_en,
  input  logic              ovf_clr,
  input  logic [ADDR_W:0]   wq2_rd_ptr,
  output logic              wrt_inc,
  output logic [ADDR_W-1:0] wrt_addr,
  output logic [ADDR_W:0]   wrt_ptr,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   wrt_level,
  output logic              overflow
);
  localparam int PW = ADDR_W + 1;
  logic [ADDR_W:0] r_bin, r_gray, r_level;
  logic [ADDR_W:0] w_bin_next, w_gray_next, w_rd_bin, w_level_next;
  logic            r_full, r_af, r_ovf, w_full_next, w_af_next;

  gray2bin #(.W(PW)) u_rd_g2b (.i_gray(wq2_rd_ptr), .o_bin(w_rd_bin));

  assign wrt_inc = wrt_en & ~r_full;

  // level is measured against a late read pointer, so it can only over-report
  always_comb begin
    w_bin_next   = r_bin + PW'(wrt_inc);
    w_gray_next  = (w_bin_next >> 1) ^ w_bin_next;
    w_full_next  = w_gray_next == {~wq2_rd_ptr[ADDR_W:ADDR_W-1], wq2_rd_ptr[ADDR_W-2:0]};
    w_level_next = w_bin_next - w_rd_bin;
    w_af_next    = w_level_next >= PW'(AF_THRESH);
  end

  always_ff @(posedge wrt_clk or negedge wrt_rst_n) begin
    if (!wrt_rst_n) begin
      r_bin   <= '0;
      r_gray  <= '0;
      r_level <= '0;
      r_full  <= 1'b0;
      r_af    <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_bin   <= w_bin_next;
      r_gray  <= w_gray_next;
      r_level <= w_level_next;
      r_full  <= w_full_next;
      r_af    <= w_af_next;
      r_ovf   <= (wrt_en & r_full) | (r_ovf & ~ovf_clr);
    end
  end

  assign wrt_addr    = r_bin[ADDR_W-1:0];
  assign wrt_ptr     = r_gray;
  assign full        = r_full;
  assign almost_full = r_af;
  assign wrt_level   = r_level;
  assign overflow    = r_ovf;
endmodule

// File: tb/tb_wrt_ptr_ctrl.sv
// tb_wrt_ptr_ctrl: scoreboard bench driving wrt_ptr_ctrl against a write/read count model
module tb_wrt_ptr_ctrl;
  localparam int AW = 3;
  localparam int AF = 6;
  logic          wrt_clk = 0, wrt_rst_n = 0, wrt_en = 0, ovf_clr = 0;
  logic [AW:0]   wq2_rd_ptr = '0;
  logic          wrt_inc, full, almost_full, overflow;
  logic [AW-1:0] wrt_addr;
  logic [AW:0]   wrt_ptr, wrt_level;

  wrt_ptr_ctrl #(.ADDR_W(AW), .AF_THRESH(AF)) dut (
    .wrt_clk(wrt_clk), .wrt_rst_n(wrt_rst_n), .wrt_en(wrt_en), .ovf_clr(ovf_clr),
    .wq2_rd_ptr(wq2_rd_ptr), .wrt_inc(wrt_inc), .wrt_addr(wrt_addr), .wrt_ptr(wrt_ptr),
    .full(full), .almost_full(almost_full), .wrt_level(wrt_level), .overflow(overflow)
  );

  always #5 wrt_clk = ~wrt_clk;

  typedef struct {
    bit inc; int addr_pre; int ptr; bit full; bit af; int level; bit ovf; int addr;
  } exp_t;
  exp_t q[$];
  int tests = 0, fails = 0;
  int m_wr = 0, m_rd = 0;
  bit m_full = 0, m_ovf = 0;

  function automatic int gray(int b);
    return (b ^ (b >> 1)) & 15;
  endfunction

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // one clock of stimulus; model works in plain write/read totals
  task automatic step(bit en, bit clr, int rd);
    exp_t e;
    int lvl;
    @(negedge wrt_clk);
    wrt_en = en; ovf_clr = clr; m_rd = rd; wq2_rd_ptr = 4'(gray(rd % 16));
    e.inc = en && !m_full;
    e.addr_pre = m_wr % 8;
    m_ovf = (en && m_full) || (m_ovf && !clr);
    m_wr += int'(e.inc);
    lvl = m_wr - rd;
    assert (lvl >= 0 && lvl <= 8) else $error("illegal read pointer, level %0d", lvl);
    m_full = (lvl == 8);
    e.ptr = gray(m_wr % 16); e.full = m_full; e.af = lvl >= AF; e.level = lvl;
    e.ovf = m_ovf; e.addr = m_wr % 8;
    q.push_back(e);
  endtask

  task automatic do_reset();
    @(posedge wrt_clk); #3;
    wrt_rst_n = 0; wrt_en = 0; ovf_clr = 0; wq2_rd_ptr = '0;
    #1;
    chk("rst_inc", wrt_inc, 0); chk("rst_addr", wrt_addr, 0); chk("rst_ptr", wrt_ptr, 0);
    chk("rst_full", full, 0); chk("rst_af", almost_full, 0);
    chk("rst_level", wrt_level, 0); chk("rst_ovf", overflow, 0);
    m_wr = 0; m_rd = 0; m_full = 0; m_ovf = 0;
    @(negedge wrt_clk); #1 wrt_rst_n = 1;
  endtask

  initial begin : monitor
    exp_t e;
    bit   inc_s;
    int   addr_s;
    forever begin
      @(negedge wrt_clk); #2;
      if (q.size() != 0) begin
        inc_s = wrt_inc; addr_s = wrt_addr;
        @(posedge wrt_clk); #1;
        e = q.pop_front();
        chk("wrt_inc", inc_s, e.inc); chk("addr_pre", addr_s, e.addr_pre);
        chk("wrt_ptr", wrt_ptr, e.ptr); chk("full", full, e.full);
        chk("almost_full", almost_full, e.af); chk("wrt_level", wrt_level, e.level);
        chk("overflow", overflow, e.ovf); chk("wrt_addr", wrt_addr, e.addr);
      end
    end
  end

  initial begin : stim
    int rd;
    #2;
    chk("init_ptr", wrt_ptr, 0); chk("init_full", full, 0);
    chk("init_level", wrt_level, 0); chk("init_ovf", overflow, 0);
    #5 wrt_rst_n = 1;
    repeat (8) step(1, 0, 0);
    repeat (3) step(1, 0, 0);
    step(1, 1, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    step(0, 0, 4);
    repeat (20) step(1, 0, (m_wr - 2 > m_rd) ? m_wr - 2 : m_rd);
    step(0, 0, m_wr - 7);
    step(1, 0, m_rd + 1);
    repeat (3) step(1, 0, m_rd);
    do_reset();
    step(1, 0, 0);
    repeat (400) begin
      rd = m_rd;
      if ($urandom_range(0, 2) == 0) rd = m_rd + int'($urandom_range(0, m_wr - m_rd));
      step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, rd);
    end
    do_reset();
    repeat (30) step($urandom_range(0, 1) == 1, 1'b0, m_rd + int'($urandom_range(0, m_wr - m_rd)));
    repeat (4) @(negedge wrt_clk);
    if (q.size() != 0) chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
